// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helpers for the multi-cycle divider.
// Build option: DIV_BYZERO_FAST_EN selects the early-exit path for a zero divisor.
package div_pkg;

    localparam int RegBusWidth       = 32;
    localparam int DoubleRegBusWidth = 64;

    typedef logic [RegBusWidth-1:0]       reg_bus_t;
    typedef logic [DoubleRegBusWidth-1:0] double_reg_bus_t;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam reg_bus_t        ZeroWord       = 32'h0000_0000;
    localparam double_reg_bus_t ZeroDoubleWord = 64'h0;

    // One restoring step per edge; 32 steps produce the raw quotient.
    localparam logic [5:0] DivSteps = 6'd32;

    function automatic reg_bus_t cond_neg(input reg_bus_t value, input logic neg);
        reg_bus_t result;
        result = neg ? (~value + 32'd1) : value;
        return result;
    endfunction

    function automatic reg_bus_t magnitude(input reg_bus_t value, input logic is_signed);
        return cond_neg(value, is_signed & value[RegBusWidth-1]);
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring 32-bit divider answering DIV/DIVU for the execute stage.
// Build option: DIV_BYZERO_FAST_EN returns 0 two edges after a zero-divisor request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DivFree   | idle, waiting for start_i with annul_i low
// DivByZero | zero divisor seen, result 0 posted on the next edge
// DivOn     | 32 restoring steps, then sign correction and result post
// DivEnd    | result held with ready_o high until start_i drops
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e      r_state;
    div_state_e      w_state_nxt;
    logic [5:0]      r_cnt;
    logic [64:0]     r_dividend;
    reg_bus_t        r_divisor;
    logic            r_neg_quot;
    logic            r_neg_rem;

    logic            w_accept;
    logic            w_div_by_zero;
    logic            w_steps_done;
    logic [32:0]     w_trial;
    reg_bus_t        w_op1_abs;
    reg_bus_t        w_op2_abs;
    reg_bus_t        w_quot;
    reg_bus_t        w_rem;
    double_reg_bus_t w_result_nxt;
    logic            w_ready_nxt;

    assign w_accept     = (start_i == DivStart) && !annul_i;
    assign w_steps_done = (r_cnt == DivSteps);

`ifdef DIV_BYZERO_FAST_EN
    assign w_div_by_zero = (opdata2_i == ZeroWord);
`else
    assign w_div_by_zero = 1'b0;
`endif

    assign w_op1_abs = magnitude(opdata1_i, signed_div_i);
    assign w_op2_abs = magnitude(opdata2_i, signed_div_i);

    // A borrow means the divisor did not fit; the shifted-in 0 is the quotient bit.
    assign w_trial = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

    assign w_quot = cond_neg(r_dividend[31:0], r_neg_quot);
    assign w_rem  = cond_neg(r_dividend[64:33], r_neg_rem);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= DivFree;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DivFree: begin
                if (w_accept) begin
                    w_state_nxt = w_div_by_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                w_state_nxt = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_nxt = DivFree;
                end else if (w_steps_done) begin
                    w_state_nxt = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_nxt = DivFree;
                end
            end
            default: w_state_nxt = DivFree;
        endcase
    end

    always_comb begin
        w_result_nxt = result_o;
        w_ready_nxt  = ready_o;
        unique case (r_state)
            DivFree: begin
                w_result_nxt = ZeroDoubleWord;
                w_ready_nxt  = DivResultNotReady;
            end
            DivByZero: begin
                w_result_nxt = ZeroDoubleWord;
                w_ready_nxt  = DivResultReady;
            end
            DivOn: begin
                if (!annul_i && w_steps_done) begin
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_result_nxt = ZeroDoubleWord;
                    w_ready_nxt  = DivResultNotReady;
                end
            end
            default: begin
                w_result_nxt = ZeroDoubleWord;
                w_ready_nxt  = DivResultNotReady;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            result_o <= ZeroDoubleWord;
            ready_o  <= DivResultNotReady;
        end else begin
            result_o <= w_result_nxt;
            ready_o  <= w_ready_nxt;
        end
    end

    // Operands and sign flags are captured once so the requester may move on.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_cnt      <= 6'd0;
            r_dividend <= 65'd0;
            r_divisor  <= ZeroWord;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else begin
            unique case (r_state)
                DivFree: begin
                    r_cnt <= 6'd0;
                    if (w_accept && !w_div_by_zero) begin
                        r_dividend <= {32'd0, w_op1_abs, 1'b0};
                        r_divisor  <= w_op2_abs;
                        r_neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_rem  <= signed_div_i & opdata1_i[31];
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        r_cnt <= 6'd0;
                    end else if (!w_steps_done) begin
                        if (w_trial[32]) begin
                            r_dividend <= {r_dividend[63:0], 1'b0};
                        end else begin
                            r_dividend <= {w_trial[31:0], r_dividend[31:0], 1'b1};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed and randomised checks of the divider against a reference model and scoreboard.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [63:0] exp_q[$];

    localparam int LatNormal = 34;
`ifdef DIV_BYZERO_FAST_EN
    localparam int LatZero = 2;
`else
    localparam int LatZero = 34;
`endif

    div u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
`ifdef DIV_BYZERO_FAST_EN
            q = 32'd0;
            r = 32'd0;
`else
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
`endif
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic count_ready_highs(input int n, input string tag);
        int highs;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) highs++;
        end
        check(tag, 64'(highs), 64'd0);
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input string tag);
        logic [63:0] exp;
        int          edges;
        int          exp_lat;
        exp_q.push_back(model(s, a, b));
        exp_lat = (b == 32'd0) ? LatZero : LatNormal;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~s;
            end
        end while (ready_o !== 1'b1 && edges < 100);
        check({tag, " latency"}, 64'(edges), 64'(exp_lat));
        exp = exp_q.pop_front();
        check({tag, " result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold result"}, result_o, exp);
            check({tag, " hold ready"}, {63'd0, ready_o}, 64'd1);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop ready"}, {63'd0, ready_o}, 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 64'd0);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 5, "udiv 100/7");
        check("udiv 100/7 const", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "sdiv -7/2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "sdiv ovf");
        run_div(1'b0, 32'd7, 32'd0, 1, "udiv 7/0");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 0, "sdiv -7/0");
        run_div(1'b1, 32'd50, 32'hFFFF_FFFB, 0, "sdiv 50/-5");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "udiv max/1");

        // Annul while cnt is 10: the division must be dropped, never reporting ready.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready", {63'd0, ready_o}, 64'd0);
        check("annul result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        count_ready_highs(40, "annul no ready");
        run_div(1'b0, 32'd9, 32'd3, 0, "udiv 9/3");

        // Start together with annul in FREE must not launch a division.
        @(negedge clk);
        opdata1_i = 32'd40;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        count_ready_highs(40, "start+annul no ready");

        // Synchronous reset while cnt is 20.
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun reset ready", {63'd0, ready_o}, 64'd0);
        check("midrun reset result", result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        count_ready_highs(40, "midrun reset no ready");

        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd1;
            run_div(k[0], a, b, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving DIV/DIVU, the responder for the execute stage's divider request port. The execute stage raises start with operands and holds its stall request until `ready_o` is seen. The block then returns the 64-bit {remainder, quotient} that the execute stage writes to HI/LO. It sits beside the execute stage in the pipeline top and is clocked with it; the pipeline flush/annul signal can abort it.

## Interface
- Parameters: none. Width fixed at 32 (`RegBus`); result width 64 (`DoubleRegBus`).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset (`RstEnable`).
- `signed_div_i` in 1: 1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `start_i` in 1: `DivStart`/`DivStop` request level.
- `annul_i` in 1: abort current division.
- `result_o` out 64: [63:32] remainder (HI), [31:0] quotient (LO).
- `ready_o` out 1: `DivResultReady`/`DivResultNotReady`.

## Operation
- State register uses 2 bits. States: FREE, BYZERO, ON, END.
- A 6-bit counter `cnt` tracks iterations. A 65-bit working register `dividend` and a 32-bit register `divisor` hold the latched operands.
- **FREE**
  - Taken when `start_i`=1 and `annul_i`=0.
  - Divisor zero: go to BYZERO (macro enabled).
  - Otherwise: latch operands and go to ON with `cnt`=0.
    - For signed, each negative operand is latched as its two's complement magnitude.
    - `dividend` ← {32'b0, |op1|, 1'b0}; `divisor` ← |op2|.
  - Later changes to `opdata*_i` or `signed_div_i` are ignored until the next FREE.
- **BYZERO**
  - Next edge: go to END.
  - `result_o` ← 0; `ready_o` ← 1.
- **ON**
  - `annul_i`=1: go to FREE, `cnt` ← 0, outputs unchanged (0). This check has priority over everything else in ON.
  - `start_i` is ignored in ON.
  - While `cnt`≠32, perform one restoring step and increment `cnt`:
    - Compute the 33-bit trial value t = {1'b0, dividend[63:32]} − {1'b0, divisor}.
    - If t[32] (borrow): `dividend` ← {dividend[63:0], 1'b0}.
    - Else: `dividend` ← {t[31:0], dividend[31:0], 1'b1}.
  - When `cnt`=32: raw quotient q = dividend[31:0]; raw remainder r = dividend[64:33].
  - For signed division, apply sign correction:
    - Negate q if op1[31]^op2[31].
    - Negate r if op1[31].
  - Register `result_o` ← {r, q}, set `ready_o` ← 1, and go to END.
  - Overflow case 0x80000000 / −1 wraps to quotient 0x80000000, remainder 0.
- **END**
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - `start_i`=0: go to FREE, `ready_o` ← 0, `result_o` ← 0.
- Reset in any state, including mid-ON, gives FREE, `cnt`=0, `result_o`=0, `ready_o`=0 at that edge.

## Timing
- Reset values: `result_o`=64'h0, `ready_o`=0.
- All outputs are registered; there is no combinational input-to-output path.
- Normal latency: counting the edge that samples `start_i` in FREE as edge 1, `ready_o` and `result_o` become valid after edge 34 (32 steps plus a correction edge).
- Divide-by-zero latency (macro on): valid after edge 2.
- Handshake:
  - The requester keeps `start_i` high until it samples `ready_o`=1, then drops it.
  - `ready_o` falls on the edge after `start_i` is seen low in END.
  - A new request is accepted no earlier than the following edge, once in FREE.
- Simultaneous `start_i` and `annul_i` in FREE: annul wins and the state stays FREE.

## Configuration
- `DIV_BYZERO_FAST_EN` defined:
  - A zero divisor takes the BYZERO path.
  - Result is 0 and is ready after edge 2.
- `DIV_BYZERO_FAST_EN` undefined:
  - BYZERO state is unreachable; a zero divisor runs the normal 32-step path.
  - Natural restoring result: raw quotient 0xFFFFFFFF, raw remainder = |op1|, then normal sign correction; ready after edge 34.
- Both behaviours are architecturally legal (the result is UNPREDICTABLE in MIPS).

## Structure
- `defines.v` holds the shared constants:
  - state encodings `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11;
  - `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`;
  - `RegBus`, `DoubleRegBus`, `ZeroWord`.
- Single module; the trial subtraction is inline. No sub-module is warranted.

## Test plan
- Unsigned 100/7, start held → `ready_o` rises after edge 34 with `result_o` = {32'd2, 32'd14}.
- Signed −7/2 (0xFFFFFFF9 / 2) → {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- Divide by zero:
  - unsigned 7/0 with macro → ready after edge 2, result 0;
  - without macro → ready after edge 34, result {32'd7, 32'hFFFFFFFF}.
- `annul_i` pulsed at `cnt`=10 → FREE next edge, `ready_o` stays 0. A follow-up unsigned 9/3 then yields {0, 3}.
- Handshake and reset:
  - After ready, hold `start_i` 5 cycles → result stable, `ready_o`=1.
  - Drop `start_i` → `ready_o`=0 and `result_o`=0 next edge.
  - `rst` asserted at `cnt`=20 → all outputs 0, FREE.
